// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson counter into a binary/one-hot phase, tracks
// sequence lock with a small FSM, counts locked rotations and flags errors.
module johnson_phase_decoder #(
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    input  logic       clr_err,
    output logic [2:0] phase,
    output logic [7:0] phase_oh,
    output logic       valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] rot_cnt
);

    typedef enum logic [1:0] {StIdle, StAcq, StLocked} state_e;
    typedef enum logic [2:0] {
        ClsNone, ClsSucc, ClsRepeat, ClsResync, ClsJump, ClsIllegal
    } cls_e;

    localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

    state_e     state;
    logic [3:0] good;
    logic       legal;
    logic [2:0] idx;
    logic [2:0] next_idx;
    logic [3:0] good_inc;
    cls_e       cls;

    always_comb begin
        legal = 1'b1;
        idx   = 3'd0;
        case (cnt_in)
            4'b0000: idx = 3'd0;
            4'b0001: idx = 3'd1;
            4'b0011: idx = 3'd2;
            4'b0111: idx = 3'd3;
            4'b1111: idx = 3'd4;
            4'b1110: idx = 3'd5;
            4'b1100: idx = 3'd6;
            4'b1000: idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    assign next_idx = phase + 3'd1;
    assign good_inc = good + 4'd1;

    // valid doubles as "previous sample present and legal"; it is clear
    // after reset, so the first sample can never be SUCC/JUMP/RESYNC.
    always_comb begin
        cls = ClsNone;
        if (!legal) begin
            cls = ClsIllegal;
        end else if (valid) begin
            if (idx == next_idx) begin
                cls = ClsSucc;
            end else if (idx == phase) begin
                cls = ClsRepeat;
            end else if (idx == 3'd0) begin
                cls = ClsResync;
            end else begin
                cls = ClsJump;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            good     <= 4'd0;
            phase    <= 3'd0;
            phase_oh <= 8'd0;
            valid    <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            rot_cnt  <= 8'd0;
        end else begin
            phase    <= legal ? idx : 3'd0;
            phase_oh <= legal ? (8'd1 << idx) : 8'd0;
            valid    <= legal;

            // Later assignment wins: a new error overrides a same-edge clear.
            if (clr_err) begin
                err <= 1'b0;
            end
            if (cls == ClsIllegal || (cls == ClsJump && state != StIdle)) begin
                err <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (legal) begin
                        state <= StAcq;
                        good  <= 4'd0;
                    end
                end
                StAcq: begin
                    case (cls)
                        ClsSucc: begin
                            good <= good_inc;
                            if (good_inc == LockCnt) begin
                                state  <= StLocked;
                                locked <= 1'b1;
                            end
                        end
                        ClsResync, ClsJump: good <= 4'd0;
                        ClsIllegal: begin
                            state <= StIdle;
                            good  <= 4'd0;
                        end
                        default: ;
                    endcase
                end
                StLocked: begin
                    case (cls)
                        ClsSucc: begin
                            if (phase == 3'd7) begin
                                rot_cnt <= rot_cnt + 8'd1;
                            end
                        end
                        ClsResync, ClsJump: begin
                            state  <= StAcq;
                            good   <= 4'd0;
                            locked <= 1'b0;
                        end
                        ClsIllegal: begin
                            state  <= StIdle;
                            good   <= 4'd0;
                            locked <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    state  <= StIdle;
                    good   <= 4'd0;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive legal successor steps needed to enter LOCKED (range 1..15).
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Port cnt_in SHALL be an input, 4 bits: Johnson code from the upstream 4-bit Johnson counter.
REQ-005 Port clr_err SHALL be an input, 1 bit: synchronous clear of the sticky err flag.
REQ-006 Port phase SHALL be an output, 3 bits: binary phase index of the last sample.
REQ-007 Port phase_oh SHALL be an output, 8 bits: one-hot phase, with bit[phase] set.
REQ-008 Port valid SHALL be an output, 1 bit: the last sample was one of the 8 legal codes.
REQ-009 Port locked SHALL be an output, 1 bit: the FSM is in LOCKED.
REQ-010 Port err SHALL be an output, 1 bit: sticky sequence/code error flag.
REQ-011 Port rot_cnt SHALL be an output, 8 bits: count of completed rotations while locked.

Function
REQ-012 Legal codes and their indices SHALL be 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7; the successor of index i SHALL be (i+1) mod 8.
REQ-013 cnt_in SHALL be sampled every rising edge; phase, phase_oh and valid SHALL reflect that sample immediately after the same edge (1-cycle latency).
REQ-014 For an illegal sample: valid SHALL be 0, phase SHALL be 0 and phase_oh SHALL be 00000000.
REQ-015 Each sample SHALL be classified against the previous registered sample as one of: SUCC (legal successor), REPEAT (same legal code), RESYNC (0000 that is not a successor), JUMP (another legal non-successor), or ILLEGAL (not a legal code).
REQ-016 The FSM SHALL have three states: IDLE, ACQ and LOCKED; a 4-bit good counter SHALL track progress toward lock.
REQ-017 In IDLE: a legal sample SHALL move the FSM to ACQ with good=0; an ILLEGAL sample SHALL set err and keep the FSM in IDLE.
REQ-018 In ACQ: SUCC SHALL increment good, and good reaching LOCK_CNT SHALL move the FSM to LOCKED; REPEAT SHALL hold good.
REQ-019 In ACQ: RESYNC SHALL reset good to 0 without setting err; JUMP SHALL reset good to 0 and set err; ILLEGAL SHALL set err and move the FSM to IDLE.
REQ-020 In LOCKED: SUCC and REPEAT SHALL keep the FSM in LOCKED.
REQ-021 In LOCKED: RESYNC SHALL move the FSM to ACQ with good=0 and no err; JUMP SHALL move it to ACQ with good=0 and set err; ILLEGAL SHALL set err and move it to IDLE.
REQ-022 locked SHALL be a registered decode of the FSM state, asserting on the edge at which the FSM enters LOCKED.
REQ-023 rot_cnt SHALL increment by 1 on a SUCC from 1000 to 0000 only when the FSM is LOCKED before that edge, SHALL wrap from 255 to 0, and SHALL NOT be changed by RESYNC or by lock loss.
REQ-024 err SHALL stay set until clr_err=1 is sampled; when clr_err=1 and a new error occur on the same edge, err SHALL remain 1 (set wins).
REQ-025 The first sample after reset SHALL have no predecessor and SHALL never be classified SUCC, JUMP or RESYNC.

Reset
REQ-026 While rst=1, asynchronously: phase=0, phase_oh=00000000, valid=0, locked=0, err=0, rot_cnt=0, FSM=IDLE, good=0, and the previous-sample register marked empty.
REQ-027 Reset asserted mid-operation SHALL discard lock, error and rotation history; behaviour after release SHALL match the behaviour after power-up reset.

Verification
REQ-028 Scenario: rst released, then cnt_in steps 0000,0001,0011,0111,1111 -> valid=1 on every sample, phase=0..4, locked rises on the edge sampling 1111 (LOCK_CNT=4), err=0.
REQ-029 Scenario: locked, then 3 full rotations of 8 codes -> rot_cnt=3 and locked stays 1 throughout.
REQ-030 Scenario: locked at 0011, then 0011 held for 5 cycles, then 0111 -> locked stays 1, err=0, phase=2 during the hold.
REQ-031 Scenario: locked at 0111, then 0000 (upstream load) -> locked=0, err=0, FSM=ACQ; 4 further successor steps -> locked=1.
REQ-032 Scenario: locked, then 0101 sampled -> valid=0, phase_oh=00000000, err=1, FSM=IDLE; clr_err pulsed on the same edge as a JUMP -> err stays 1; clr_err pulsed alone -> err=0.
REQ-033 Scenario: rst asserted asynchronously mid-rotation with rot_cnt=5 -> all outputs take their REQ-026 values immediately, before the next clock edge.
